// File: rtl/adc_align_ctrl.sv
// Frame-alignment controller in the divclk domain: pulses bitslip until the frame-clock word
// matches FCLK_PATTERN, confirms lock, then holds it. ADC_ALIGN_LOSS_MONITOR_EN enables loss-of-lock monitoring.
module adc_align_ctrl #(
    parameter logic [7:0]  FCLK_PATTERN  = 8'h0F,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned MAX_SLIPS     = 8,
    parameter int unsigned VERIFY_CYCLES = 32,
    parameter int unsigned LOSS_THRESH   = 4
) (
    input  logic       divclk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] fclk_deser,
    output logic       bitslip,
    output logic       locked,
    output logic       align_fail,
    output logic [3:0] slip_count,
    output logic [7:0] relock_count,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_VERIFY = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } state_e;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] VERIFY_LAST = 8'(VERIFY_CYCLES - 1);
    localparam logic [3:0] SLIP_LIMIT  = 4'(MAX_SLIPS);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || MAX_SLIPS < 1 || MAX_SLIPS > 15 ||
            VERIFY_CYCLES < 1 || VERIFY_CYCLES > 255 || LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_param_check
            $error("adc_align_ctrl: parameter out of range");
        end
    endgenerate

    state_e     state_q, state_d;
    logic [3:0] slip_q, slip_d;
    logic [7:0] settle_q, settle_d;
    logic [7:0] verify_q, verify_d;
    logic       bitslip_q, bitslip_d;
    logic       locked_q, locked_d;
    logic       fail_q, fail_d;
    logic       match;

`ifdef ADC_ALIGN_LOSS_MONITOR_EN
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_THRESH - 1);
    logic [3:0] loss_q, loss_d;
    logic [7:0] relock_q, relock_d;
`endif

    always_comb begin
        state_d  = state_q;
        slip_d   = slip_q;
        settle_d = settle_q;
        verify_d = verify_q;
        match    = (fclk_deser == FCLK_PATTERN);
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
        loss_d   = loss_q;
        relock_d = relock_q;
`endif
        // enable low overrides every other transition, including a same-cycle loss event
        if (!enable) begin
            state_d  = ST_IDLE;
            slip_d   = 4'd0;
            settle_d = 8'd0;
            verify_d = 8'd0;
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
            loss_d   = 4'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    slip_d  = 4'd0;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (match) begin
                        state_d  = ST_VERIFY;
                        verify_d = 8'd0;
                    end else if (slip_q == SLIP_LIMIT) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                        slip_d  = slip_q + 4'd1;
                    end
                end
                ST_SLIP: begin
                    state_d  = ST_SETTLE;
                    settle_d = 8'd0;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
                    else settle_d = settle_q + 8'd1;
                end
                ST_VERIFY: begin
                    if (!match) begin
                        state_d  = ST_CHECK;
                        verify_d = 8'd0;
                    end else if (verify_q == VERIFY_LAST) begin
                        state_d = ST_LOCKED;
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
                        loss_d  = 4'd0;
`endif
                    end else begin
                        verify_d = verify_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
                    if (match) begin
                        loss_d = 4'd0;
                    end else if (loss_q == LOSS_LAST) begin
                        state_d  = ST_CHECK;
                        slip_d   = 4'd0;
                        loss_d   = 4'd0;
                        relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    end else begin
                        loss_d = loss_q + 4'd1;
                    end
`endif
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_IDLE;
            endcase
        end
        // outputs are decoded from the next state so they are valid in the cycle the state is entered
        bitslip_d = (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
    end

    always_ff @(posedge divclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            slip_q    <= 4'd0;
            settle_q  <= 8'd0;
            verify_q  <= 8'd0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
            loss_q    <= 4'd0;
            relock_q  <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            slip_q    <= slip_d;
            settle_q  <= settle_d;
            verify_q  <= verify_d;
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
            loss_q    <= loss_d;
            relock_q  <= relock_d;
`endif
        end
    end

    assign bitslip    = bitslip_q;
    assign locked     = locked_q;
    assign align_fail = fail_q;
    assign slip_count = slip_q;
    assign state_dbg  = state_q;
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Bench for adc_align_ctrl: models the deserializer as a word rotated one bit per bitslip
// pulse and predicts pulse times, lock/fail latency and status from the alignment rules.
`timescale 1ns/1ps
module tb_adc_align_ctrl;

    localparam logic [7:0] PAT    = 8'h0F;
    localparam int         SETTLE = 16;
    localparam int         MAXS   = 8;
    localparam int         VER    = 32;
    localparam int         LOSS   = 4;
    localparam int         PERIOD = SETTLE + 2;

    logic       divclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] fclk_deser = 8'h00;
    logic       bitslip;
    logic       locked;
    logic       align_fail;
    logic [3:0] slip_count;
    logic [7:0] relock_count;
    logic [2:0] state_dbg;

    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    int          pulses = 0;
    logic        prev_bs = 1'b0;
    logic [7:0]  word = 8'h00;
    logic [15:0] exp_q[$];

    adc_align_ctrl #(
        .FCLK_PATTERN(PAT), .SETTLE_CYCLES(SETTLE), .MAX_SLIPS(MAXS),
        .VERIFY_CYCLES(VER), .LOSS_THRESH(LOSS)
    ) dut (
        .divclk(divclk), .rst_n(rst_n), .enable(enable), .fclk_deser(fclk_deser),
        .bitslip(bitslip), .locked(locked), .align_fail(align_fail),
        .slip_count(slip_count), .relock_count(relock_count), .state_dbg(state_dbg)
    );

    always #5 divclk = ~divclk;

    function automatic logic [7:0] ror_k(input logic [7:0] w, input int k);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < k; i++) r = {r[0], r[7:1]};
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] w);
        return {w[6:0], w[7]};
    endfunction

    task automatic drive_word(input logic [7:0] w);
        word = w;
        fclk_deser = word;
    endtask

    // One divclk cycle: sample at the falling edge, score bitslip against the expected
    // pulse queue, then let the deserializer model react to a pulse.
    task automatic tick();
        logic [15:0] exp_v;
        @(negedge divclk);
        n++;
        checks++;
        if (bitslip === 1'b1 && prev_bs === 1'b1) begin
            failures++;
            $display("FAIL bitslip_consecutive n=%0d actual=1 required=0", n);
        end
        checks++;
        if (locked !== (state_dbg == 3'd5) || align_fail !== (state_dbg == 3'd6)) begin
            failures++;
            $display("FAIL status_vs_state n=%0d locked=%0b fail=%0b state=%0d", n, locked, align_fail, state_dbg);
        end
        prev_bs = bitslip;
        if (bitslip === 1'b1) begin
            pulses++;
            checks++;
            if (state_dbg !== 3'd2) begin
                failures++;
                $display("FAIL bitslip_state n=%0d actual=%0d required=2", n, state_dbg);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse n=%0d actual=pulse required=none", n);
            end else begin
                exp_v = exp_q.pop_front();
                if (16'(n) !== exp_v) begin
                    failures++;
                    $display("FAIL pulse_time actual=%0d required=%0d", n, exp_v);
                end
            end
            drive_word(rotl(word));
        end
    endtask

    task automatic align_run(input logic [7:0] w0, input int k, input string tag);
        int lock_n;
        drive_word(w0);
        exp_q.delete();
        for (int j = 1; j <= k; j++) exp_q.push_back(16'(2 + PERIOD * (j - 1)));
        pulses = 0;
        n = 0;
        lock_n = -1;
        enable = 1'b1;
        while (lock_n < 0 && n < 2000) begin
            tick();
            if (locked === 1'b1) lock_n = n;
        end
        checks++;
        if (lock_n != PERIOD * k + 2 + VER) begin
            failures++;
            $display("FAIL %s_lock_time actual=%0d required=%0d", tag, lock_n, PERIOD * k + 2 + VER);
        end
        checks++;
        if (pulses != k || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pulses actual=%0d required=%0d", tag, pulses, k);
        end
        checks++;
        if (slip_count !== 4'(k)) begin
            failures++;
            $display("FAIL %s_slip_count actual=%0d required=%0d", tag, slip_count, k);
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if (state_dbg !== 3'd0 || locked !== 1'b0 || align_fail !== 1'b0 || slip_count !== 4'd0) begin
            failures++;
            $display("FAIL idle_return state=%0d locked=%0b fail=%0b slips=%0d required=0", state_dbg, locked, align_fail, slip_count);
        end
        tick();
    endtask

    task automatic test_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge divclk);
        checks++;
        if ({bitslip, locked, align_fail, slip_count, relock_count, state_dbg} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%0h required=0", {bitslip, locked, align_fail, slip_count, relock_count, state_dbg});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL reset_idle actual=%0d required=0", state_dbg);
        end
    endtask

    task automatic test_aligned();
        align_run(PAT, 0, "aligned");
        go_idle();
    endtask

    task automatic test_rotating();
        int k;
        align_run(ror_k(PAT, 3), 3, "rot3");
        go_idle();
        for (int t = 0; t < 3; t++) begin
            k = int'($urandom_range(1, 7));
            align_run(ror_k(PAT, k), k, "rot_rand");
            go_idle();
        end
    endtask

    task automatic test_no_match();
        int fail_n;
        drive_word(8'h00);
        exp_q.delete();
        for (int j = 1; j <= MAXS; j++) exp_q.push_back(16'(2 + PERIOD * (j - 1)));
        pulses = 0;
        n = 0;
        fail_n = -1;
        enable = 1'b1;
        while (fail_n < 0 && n < 1000) begin
            tick();
            if (align_fail === 1'b1) fail_n = n;
        end
        checks++;
        if (fail_n != PERIOD * MAXS + 2) begin
            failures++;
            $display("FAIL fail_time actual=%0d required=%0d", fail_n, PERIOD * MAXS + 2);
        end
        repeat (40) tick();
        checks++;
        if (pulses != MAXS || align_fail !== 1'b1 || slip_count !== 4'(MAXS)) begin
            failures++;
            $display("FAIL fail_hold pulses=%0d fail=%0b slips=%0d required=%0d/1/%0d", pulses, align_fail, slip_count, MAXS, MAXS);
        end
        go_idle();
    endtask

    task automatic test_loss();
        logic [7:0] bad;
        int c;
        int lock_n;
        bad = ror_k(PAT, 1);
        align_run(PAT, 0, "loss_pre");
        for (int i = 0; i < 4; i++) begin
            drive_word((i < 3) ? bad : PAT);
            tick();
            checks++;
            if (locked !== 1'b1) begin
                failures++;
                $display("FAIL loss_short_run i=%0d actual=%0b required=1", i, locked);
            end
        end
        for (int i = 1; i <= LOSS; i++) begin
            drive_word(bad);
            tick();
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
            checks++;
            if (locked !== (i < LOSS) || state_dbg !== ((i < LOSS) ? 3'd5 : 3'd1)) begin
                failures++;
                $display("FAIL loss_run i=%0d locked=%0b state=%0d required=%0b/%0d", i, locked, state_dbg, i < LOSS, (i < LOSS) ? 5 : 1);
            end
`else
            checks++;
            if (locked !== 1'b1 || state_dbg !== 3'd5) begin
                failures++;
                $display("FAIL lock_hold i=%0d locked=%0b state=%0d required=1/5", i, locked, state_dbg);
            end
`endif
        end
`ifdef ADC_ALIGN_LOSS_MONITOR_EN
        checks++;
        if (relock_count !== 8'd1) begin
            failures++;
            $display("FAIL relock_count actual=%0d required=1", relock_count);
        end
        c = n;
        pulses = 0;
        exp_q.delete();
        exp_q.push_back(16'(c + 1));
        lock_n = -1;
        while (lock_n < 0 && n < c + 500) begin
            tick();
            if (locked === 1'b1) lock_n = n;
        end
        checks++;
        if (lock_n != c + PERIOD + 1 + VER || pulses != 1 || slip_count !== 4'd1) begin
            failures++;
            $display("FAIL relock_run lock=%0d pulses=%0d slips=%0d required=%0d/1/1", lock_n, pulses, slip_count, c + PERIOD + 1 + VER);
        end
`else
        c = 0;
        lock_n = 0;
        drive_word(PAT);
        tick();
        checks++;
        if (relock_count !== 8'd0 || locked !== 1'b1 || c != lock_n) begin
            failures++;
            $display("FAIL relock_tied actual=%0d required=0", relock_count);
        end
`endif
        go_idle();
    endtask

    task automatic test_verify_glitch();
        int k;
        int v;
        int lock_n;
        logic [7:0] bad;
        k = int'($urandom_range(1, 3));
        bad = 8'($urandom_range(0, 255));
        if (bad == PAT) bad = 8'hA5;
        v = PERIOD * k + 2;
        drive_word(ror_k(PAT, k));
        exp_q.delete();
        for (int j = 1; j <= k; j++) exp_q.push_back(16'(2 + PERIOD * (j - 1)));
        pulses = 0;
        n = 0;
        lock_n = -1;
        enable = 1'b1;
        while (lock_n < 0 && n < 2000) begin
            tick();
            if (locked === 1'b1) lock_n = n;
            if (n == v + 20) drive_word(bad);
            if (n == v + 21) begin
                checks++;
                if (state_dbg !== 3'd1 || slip_count !== 4'(k)) begin
                    failures++;
                    $display("FAIL glitch_check state=%0d slips=%0d required=1/%0d", state_dbg, slip_count, k);
                end
                drive_word(PAT);
            end
        end
        checks++;
        if (lock_n != v + 54 || pulses != k || slip_count !== 4'(k)) begin
            failures++;
            $display("FAIL glitch_lock lock=%0d pulses=%0d slips=%0d required=%0d/%0d/%0d", lock_n, pulses, slip_count, v + 54, k, k);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int r;
        r = int'($urandom_range(3, SETTLE + 2));
        drive_word(ror_k(PAT, 5));
        exp_q.delete();
        exp_q.push_back(16'd2);
        pulses = 0;
        n = 0;
        enable = 1'b1;
        while (n < r) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bitslip, locked, align_fail, slip_count, relock_count, state_dbg} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset actual=%0h required=0", {bitslip, locked, align_fail, slip_count, relock_count, state_dbg});
        end
        exp_q.delete();
        prev_bs = 1'b0;
        repeat (2) @(negedge divclk);
        rst_n = 1'b1;
        align_run(word, 4, "post_reset");
        go_idle();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_rotating();
        test_no_match();
        test_loss();
        test_verify_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
